edge_capture: RTL and testbench
===============================

Name: edge_capture

Overview:
- Parametrised successor to the single-shot 8-bit trigger/data edge detector.
- Synchronises and debounces an asynchronous trigger, then detects rising, falling or both edges under a runtime mode.
- On each qualifying edge it captures a DATA_W-bit word and presents it on a valid/ready output with sticky overrun reporting.
- Sits between external/board-level trigger sources and the client command/packet logic.

Parameters:
DATA_W, 8, width of data_in / out_data
SYNC_STAGES, 2, synchroniser flops on trigger (legal 2..4)
DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the filtered level changes; 0 = bypass
INIT_LEVEL, 0, reset value of the synchroniser and the filtered level
HANDSHAKE, 1, 1 = out_valid held until out_ready; 0 = out_valid is a 1-cycle pulse, out_ready ignored (legacy)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
trigger  in  1  asynchronous trigger input
data_in  in  DATA_W  word captured on a qualifying edge
edge_mode  in  2  00 rise, 01 fall, 10 both, 11 disabled
out_ready  in  1  consumer accepts event (HANDSHAKE=1)
out_valid  out  1  event available
out_data  out  DATA_W  captured word
out_rise  out  1  1 = event was a rising edge, 0 = falling
overrun  out  1  sticky: an event was dropped
overrun_clr  in  1  clears overrun
level  out  1  current filtered trigger level

Behaviour:
- Reset (async assert, sync release): sync chain and level = INIT_LEVEL; debounce counter = 0; out_valid = 0; out_data = 0; out_rise = 0; overrun = 0.
- Sync: SYNC_STAGES-flop chain; no logic between stages.
- Debounce: counter increments while sync output != level; it clears when they agree. When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, level toggles and the counter clears. With DEBOUNCE_CYCLES=0, level = registered sync output.
- Latency: the first clock edge that samples a new trigger value is edge k. The matching out_valid rises after edge k + SYNC_STAGES + DEBOUNCE_CYCLES + 1.
- Edge: a rise is level 0->1 and a fall is level 1->0, both registered. A qualifying edge is one allowed by edge_mode as sampled in the same cycle. A mode change affects only later edges, and a held event is unaffected.
- Capture: on a qualifying edge, data_in is sampled on that same clock edge into out_data and out_rise is set.
- HANDSHAKE=1:
  - Slot empty, or out_valid && out_ready in the same cycle: load the new event; out_valid stays/becomes 1.
  - Slot full and not ready: drop the new event, keep the old one, set overrun.
  - Ready with no new edge: out_valid -> 0. out_data holds its value.
- HANDSHAKE=0: out_valid is high exactly one cycle per qualifying edge; out_data holds until the next event; overrun never sets.
- overrun: set has priority over overrun_clr in the same cycle.
- Debounce glitches: a trigger pulse shorter than DEBOUNCE_CYCLES synced cycles produces no level change and no event.
- Reset mid-operation: a pending event is lost; no event is generated by the reset itself. If trigger != INIT_LEVEL after release, a normal edge follows after the full latency.
- Counter width is $clog2(DEBOUNCE_CYCLES+1), minimum 1. The counter never wraps because it clears on toggle.

Decomposition:
- Shared package edge_capture_pkg: EDGE_RISE/EDGE_FALL/EDGE_BOTH/EDGE_OFF 2-bit constants.
- Sub-module sync_debounce (trigger -> level, with SYNC_STAGES, DEBOUNCE_CYCLES, INIT_LEVEL). It is reusable for button/strobe inputs.
- Top: edge qualify, capture slot, handshake, overrun.

Test Plan:
- Defaults, mode=00, ready=1: trigger 0->1 at edge 10 with data_in=8'hA5 -> out_valid high for one cycle after edge 13, out_data=A5, out_rise=1. Trigger 1->0 -> no event.
- mode=10, DEBOUNCE_CYCLES=4: trigger high 3 cycles then low -> no event, level stays 0. Trigger high 10 cycles with data 3C, then low with data C3 -> two events {3C, rise} and {C3, fall}, each 7 cycles after its trigger change.
- HANDSHAKE=1, ready=0: two rises with data 11 then 22 -> out_data stays 11, overrun=1. Ready pulse -> out_valid drops. overrun_clr -> overrun=0. A collision of overrun_clr with a new overrun -> overrun stays 1.
- Ready and a new edge in the same cycle with data 55 -> out_valid remains 1, out_data=55, overrun=0.
- HANDSHAKE=0, ready tied 0: three rises -> three 1-cycle out_valid pulses, overrun=0. mode=11 -> none.
- rst asserted asynchronously while out_valid=1 with trigger held high, INIT_LEVEL=0 -> outputs zero immediately. After release, one rise event after SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.

Source files
------------

// File: rtl/edge_capture_pkg.sv
// Shared constants and helpers for the edge_capture trigger block.
// Edge-mode encodings are also used by client logic that programs edge_mode.
package edge_capture_pkg;

  localparam int unsigned EDGE_MODE_W = 2;

  localparam logic [EDGE_MODE_W-1:0] EDGE_RISE = 2'b00;
  localparam logic [EDGE_MODE_W-1:0] EDGE_FALL = 2'b01;
  localparam logic [EDGE_MODE_W-1:0] EDGE_BOTH = 2'b10;
  localparam logic [EDGE_MODE_W-1:0] EDGE_OFF  = 2'b11;

  // Debounce counter width; a bypassed debouncer still gets a 1-bit counter.
  function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic logic edge_qualifies(input logic [EDGE_MODE_W-1:0] mode,
                                          input logic rise,
                                          input logic fall);
    logic q;
    q = 1'b0;
    case (mode)
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchroniser plus optional debounce filter turning an async input into a clean level.
// Reusable for buttons and board strobes as well as edge_capture triggers.
module sync_debounce
  import edge_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass

    logic level_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        level_q <= INIT_LEVEL;
      end else begin
        level_q <= sync_out;
      end
    end

    assign level_o = level_q;

  end else begin : g_debounce

    localparam int unsigned CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES - 1;

    logic             samp_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing cycles; toggle and restart once the run is long enough.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (samp_q != level_q) begin
        if (cnt_q == CNT_W'(CNT_MAX)) begin
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        samp_q  <= INIT_LEVEL;
        level_q <= INIT_LEVEL;
        cnt_q   <= '0;
      end else begin
        samp_q  <= sync_out;
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_o = level_q;

  end

endmodule

// File: rtl/edge_capture.sv
// Trigger edge detector: filters an async trigger, qualifies edges by mode and
// captures a data word into a single valid/ready slot with sticky overrun.
module edge_capture
  import edge_capture_pkg::*;
#(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        INIT_LEVEL      = 1'b0,
  parameter int unsigned HANDSHAKE       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trigger,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [EDGE_MODE_W-1:0] edge_mode,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_rise,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   level
);

  logic              level_prev_q;
  logic              rise_c;
  logic              fall_c;
  logic              evt_c;
  logic              ready_c;

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              rise_q;
  logic              rise_d;
  logic              ovr_q;
  logic              ovr_d;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .INIT_LEVEL      (INIT_LEVEL)
  ) u_sync_debounce (
    .clk_i   (clk),
    .rst_i   (rst),
    .din_i   (trigger),
    .level_o (level)
  );

  assign rise_c = level & ~level_prev_q;
  assign fall_c = ~level & level_prev_q;
  assign evt_c  = edge_qualifies(edge_mode, rise_c, fall_c);

  // Legacy pulse mode behaves as a slot whose consumer is always ready.
  assign ready_c = (HANDSHAKE != 0) ? out_ready : 1'b1;

  // Slot update: load when empty or draining, otherwise drop and flag overrun.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rise_d  = rise_q;
    ovr_d   = ovr_q;
    if (overrun_clr) begin
      ovr_d = 1'b0;
    end
    if (evt_c) begin
      if (!valid_q || ready_c) begin
        valid_d = 1'b1;
        data_d  = data_in;
        rise_d  = rise_c;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_q <= INIT_LEVEL;
      valid_q      <= 1'b0;
      data_q       <= '0;
      rise_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      level_prev_q <= level;
      valid_q      <= valid_d;
      data_q       <= data_d;
      rise_q       <= rise_d;
      ovr_q        <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_rise  = rise_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_edge_capture.sv
// Directed bench for edge_capture: handshake, debounce and pulse-mode instances.
module tb_edge_capture;

  localparam int unsigned NV = 46;

  typedef struct {
    logic       trig;
    logic [7:0] din;
    logic [1:0] mode;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       er;
    logic       eo;
    logic       el;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  logic       trig_a, rdy_a, clr_a, valid_a, orise_a, ovr_a, level_a;
  logic [7:0] data_a, odata_a;
  logic [1:0] mode_a;
  logic       trig_b, rdy_b, clr_b, valid_b, orise_b, ovr_b, level_b;
  logic [7:0] data_b, odata_b;
  logic [1:0] mode_b;
  logic       trig_c, rdy_c, clr_c, valid_c, orise_c, ovr_c, level_c;
  logic [7:0] data_c, odata_c;
  logic [1:0] mode_c;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl [NV];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  edge_capture u_a (
    .clk(clk), .rst(rst), .trigger(trig_a), .data_in(data_a), .edge_mode(mode_a),
    .out_ready(rdy_a), .out_valid(valid_a), .out_data(odata_a), .out_rise(orise_a),
    .overrun(ovr_a), .overrun_clr(clr_a), .level(level_a)
  );

  edge_capture #(.DEBOUNCE_CYCLES(4)) u_b (
    .clk(clk), .rst(rst), .trigger(trig_b), .data_in(data_b), .edge_mode(mode_b),
    .out_ready(rdy_b), .out_valid(valid_b), .out_data(odata_b), .out_rise(orise_b),
    .overrun(ovr_b), .overrun_clr(clr_b), .level(level_b)
  );

  edge_capture #(.HANDSHAKE(0)) u_c (
    .clk(clk), .rst(rst), .trigger(trig_c), .data_in(data_c), .edge_mode(mode_c),
    .out_ready(rdy_c), .out_valid(valid_c), .out_data(odata_c), .out_rise(orise_c),
    .overrun(ovr_c), .overrun_clr(clr_c), .level(level_c)
  );

  function automatic vec_t mk(input logic t, input logic [7:0] d, input logic [1:0] m,
                              input logic r, input logic c, input logic ev,
                              input logic [7:0] ed, input logic er, input logic eo,
                              input logic el);
    vec_t x;
    x.trig = t;  x.din = d;  x.mode = m;  x.rdy = r;  x.clr = c;
    x.ev = ev;   x.ed = ed;  x.er = er;   x.eo = eo;  x.el = el;
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", nm, act, exp_v);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    //          trig  din    mode   rdy   clr   | valid data   rise  ovr   level
    tbl[0]  = mk(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b1, 8'hA5, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 8'h77, 2'd0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 8'h99, 2'd0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    tbl[14] = mk(1'b1, 8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[16] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[17] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[20] = mk(1'b1, 8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1);
    tbl[21] = mk(1'b1, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1);
    tbl[22] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[23] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[24] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[25] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
    tbl[26] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
    tbl[27] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
    tbl[28] = mk(1'b0, 8'h33, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    tbl[29] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    tbl[30] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    tbl[31] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    tbl[32] = mk(1'b1, 8'h44, 2'd0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
    tbl[33] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
    tbl[34] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    tbl[35] = mk(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    tbl[36] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    tbl[37] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    tbl[38] = mk(1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    tbl[39] = mk(1'b1, 8'h55, 2'd0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    tbl[40] = mk(1'b1, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    tbl[41] = mk(1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    tbl[42] = mk(1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    tbl[43] = mk(1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    tbl[44] = mk(1'b0, 8'h66, 2'd1, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    tbl[45] = mk(1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0);

    rst    = 1'b1;
    trig_a = 1'b0; data_a = 8'h00; mode_a = 2'b00; rdy_a = 1'b1; clr_a = 1'b0;
    trig_b = 1'b0; data_b = 8'h00; mode_b = 2'b10; rdy_b = 1'b1; clr_b = 1'b0;
    trig_c = 1'b0; data_c = 8'h00; mode_c = 2'b00; rdy_c = 1'b0; clr_c = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk1("reset valid", valid_a, 1'b0);
    chk8("reset data", odata_a, 8'h00);
    chk1("reset rise", orise_a, 1'b0);
    chk1("reset overrun", ovr_a, 1'b0);
    chk1("reset level", level_a, 1'b0);
    #2 rst = 1'b0;

    // Handshake instance driven from the vector table.
    for (int i = 0; i < int'(NV); i++) begin
      trig_a = tbl[i].trig; data_a = tbl[i].din; mode_a = tbl[i].mode;
      rdy_a  = tbl[i].rdy;  clr_a  = tbl[i].clr;
      cyc();
      chk1($sformatf("vec%0d valid", i), valid_a, tbl[i].ev);
      chk8($sformatf("vec%0d data", i), odata_a, tbl[i].ed);
      chk1($sformatf("vec%0d rise", i), orise_a, tbl[i].er);
      chk1($sformatf("vec%0d overrun", i), ovr_a, tbl[i].eo);
      chk1($sformatf("vec%0d level", i), level_a, tbl[i].el);
    end

    // Debounced instance: a 3-cycle glitch must be filtered out.
    trig_b = 1'b1;
    repeat (3) cyc();
    trig_b = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      chk1($sformatf("glitch%0d valid", n), valid_b, 1'b0);
      chk1($sformatf("glitch%0d level", n), level_b, 1'b0);
    end

    trig_b = 1'b1;
    for (int n = 0; n < 10; n++) begin
      data_b = (n == 7) ? 8'h3C : 8'h00;
      cyc();
      if (n == 5) chk1("deb rise level early", level_b, 1'b0);
      if (n == 6) begin
        chk1("deb rise level", level_b, 1'b1);
        chk1("deb rise valid early", valid_b, 1'b0);
      end
      if (n == 7) begin
        chk1("deb rise valid", valid_b, 1'b1);
        chk8("deb rise data", odata_b, 8'h3C);
        chk1("deb rise flag", orise_b, 1'b1);
      end
      if (n == 8) chk1("deb rise drain", valid_b, 1'b0);
    end

    trig_b = 1'b0;
    for (int n = 0; n < 10; n++) begin
      data_b = (n == 7) ? 8'hC3 : 8'h00;
      cyc();
      if (n == 5) chk1("deb fall level early", level_b, 1'b1);
      if (n == 6) begin
        chk1("deb fall level", level_b, 1'b0);
        chk1("deb fall valid early", valid_b, 1'b0);
      end
      if (n == 7) begin
        chk1("deb fall valid", valid_b, 1'b1);
        chk8("deb fall data", odata_b, 8'hC3);
        chk1("deb fall flag", orise_b, 1'b0);
      end
      if (n == 8) chk1("deb fall drain", valid_b, 1'b0);
    end

    // Pulse-mode instance: three rises give three single-cycle pulses.
    exp_d = 8'h00;
    for (int i = 0; i < 24; i++) begin
      trig_c = ((i % 8) < 4);
      data_c = 8'(i);
      cyc();
      if ((i % 8) == 3) begin
        exp_d = 8'(i);
        chk1($sformatf("pulse%0d rise", i), orise_c, 1'b1);
      end
      chk1($sformatf("pulse%0d valid", i), valid_c, ((i % 8) == 3));
      chk8($sformatf("pulse%0d data", i), odata_c, exp_d);
      chk1($sformatf("pulse%0d overrun", i), ovr_c, 1'b0);
    end

    mode_c = 2'b11;
    for (int j = 0; j < 24; j++) begin
      trig_c = ((j % 8) < 4);
      data_c = 8'(j + 100);
      cyc();
      chk1($sformatf("off%0d valid", j), valid_c, 1'b0);
      chk8($sformatf("off%0d data", j), odata_c, 8'd19);
    end

    // Async reset while an event is held and trigger stays high.
    trig_a = 1'b1; data_a = 8'hE7; mode_a = 2'b00; rdy_a = 1'b0; clr_a = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc();
      if (n == 3) begin
        chk1("pre-reset valid", valid_a, 1'b1);
        chk8("pre-reset data", odata_a, 8'hE7);
      end
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk1("async rst valid", valid_a, 1'b0);
    chk8("async rst data", odata_a, 8'h00);
    chk1("async rst rise", orise_a, 1'b0);
    chk1("async rst overrun", ovr_a, 1'b0);
    chk1("async rst level", level_a, 1'b0);
    chk8("async rst b data", odata_b, 8'h00);
    chk1("async rst b outs", valid_b | orise_b | ovr_b | level_b, 1'b0);
    chk8("async rst c data", odata_c, 8'h00);
    chk1("async rst c outs", valid_c | orise_c | ovr_c | level_c, 1'b0);
    #2 rst = 1'b0;
    data_a = 8'h5A;
    for (int n = 0; n < 5; n++) begin
      cyc();
      if (n < 3) chk1($sformatf("post-rst%0d valid", n), valid_a, 1'b0);
      if (n == 2) chk1("post-rst level", level_a, 1'b1);
      if (n == 3) begin
        chk1("post-rst valid", valid_a, 1'b1);
        chk8("post-rst data", odata_a, 8'h5A);
        chk1("post-rst rise", orise_a, 1'b1);
      end
      if (n == 4) begin
        chk1("post-rst held", valid_a, 1'b1);
        chk1("post-rst overrun", ovr_a, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
